// File: rtl/log_scale_arbiter.sv
// Round-robin arbiter feeding one shared signed power-of-two scaler (two pipeline stages).
// Optional build macro LOG_SCALE_SAT_EN: clamp overflowed left shifts instead of wrapping.
module log_scale_arbiter #(
  parameter int width_H = 5,
  parameter int width_W = 20,
  parameter int N_CH    = 4,
  parameter int SHIFT_W = 5,
  parameter int CH_W    = $clog2(N_CH)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N_CH-1:0]                    req_valid,
  output logic [N_CH-1:0]                    req_ready,
  input  logic [N_CH*(width_H+width_W)-1:0]  req_data,
  input  logic [N_CH*SHIFT_W-1:0]            req_shift,
  output logic                               data_o_en,
  output logic [width_H+width_W-1:0]         data_o,
  output logic [CH_W-1:0]                    ch_o,
  output logic                               ovf_o,
  output logic [15:0]                        ovf_cnt
);
  localparam int DW   = width_H + width_W;
  localparam int MAXL = (1 << (SHIFT_W - 1)) - 1;
  localparam int WW   = DW + MAXL;

  // Handshake: channel i transfers in a cycle where req_valid[i] & req_ready[i];
  // the requester holds data/shift stable until then. No output backpressure.

  logic [CH_W-1:0]    ptr_q, ptr_d;
  logic               s1_valid_q, s1_valid_d;
  logic [DW-1:0]      s1_data_q, s1_data_d;
  logic [SHIFT_W-1:0] s1_shift_q, s1_shift_d;
  logic [CH_W-1:0]    s1_ch_q, s1_ch_d;
  logic               data_o_en_q, data_o_en_d;
  logic [DW-1:0]      data_o_q, data_o_d;
  logic [CH_W-1:0]    ch_o_q, ch_o_d;
  logic               ovf_o_q, ovf_o_d;
  logic [15:0]        ovf_cnt_q, ovf_cnt_d;

  logic               grant_any;
  logic [CH_W-1:0]    grant_idx;
  logic [CH_W:0]      cand;

  // Search upward from ptr, modulo N_CH; the first valid channel wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < N_CH; k++) begin
      cand = {1'b0, ptr_q} + (CH_W+1)'(k);
      if (cand >= (CH_W+1)'(N_CH)) cand = cand - (CH_W+1)'(N_CH);
      if (!grant_any && req_valid[cand[CH_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[CH_W-1:0];
      end
    end
    if (rst) grant_any = 1'b0;
  end

  always_comb begin
    req_ready  = '0;
    ptr_d      = ptr_q;
    s1_valid_d = grant_any;
    s1_data_d  = s1_data_q;
    s1_shift_d = s1_shift_q;
    s1_ch_d    = s1_ch_q;
    if (grant_any) begin
      req_ready  = N_CH'(1) << grant_idx;
      ptr_d      = (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + CH_W'(1);
      s1_data_d  = req_data[grant_idx*DW +: DW];
      s1_shift_d = req_shift[grant_idx*SHIFT_W +: SHIFT_W];
      s1_ch_d    = grant_idx;
    end
  end

  logic               in_sign;
  logic [WW-1:0]      ext;
  logic [WW-1:0]      shl;
  logic [SHIFT_W-1:0] ramt;
  logic [DW-1:0]      res;
  logic               ovf;

  // Left shifts run in a window wide enough for the largest shift, so every bit
  // pushed past the sign position is still visible for the overflow test.
  always_comb begin
    in_sign = s1_data_q[DW-1];
    ext     = {{MAXL{in_sign}}, s1_data_q};
    shl     = '0;
    ramt    = '0;
    res     = '0;
    ovf     = 1'b0;
    if (!s1_shift_q[SHIFT_W-1]) begin
      shl = ext << s1_shift_q[SHIFT_W-2:0];
      ovf = |(shl[WW-1:DW-1] ^ {(MAXL+1){in_sign}});
      res = shl[DW-1:0];
    end else begin
      ramt = SHIFT_W'(0) - s1_shift_q;
      res  = $signed(s1_data_q) >>> ramt;
    end
`ifdef LOG_SCALE_SAT_EN
    if (ovf) res = in_sign ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`endif
  end

  always_comb begin
    data_o_en_d = s1_valid_q;
    data_o_d    = data_o_q;
    ch_o_d      = ch_o_q;
    ovf_o_d     = ovf_o_q;
    ovf_cnt_d   = ovf_cnt_q;
    if (s1_valid_q) begin
      data_o_d = res;
      ch_o_d   = s1_ch_q;
      ovf_o_d  = ovf;
      if (ovf && ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_shift_q  <= '0;
      s1_ch_q     <= '0;
      data_o_en_q <= 1'b0;
      data_o_q    <= '0;
      ch_o_q      <= '0;
      ovf_o_q     <= 1'b0;
      ovf_cnt_q   <= '0;
    end else begin
      ptr_q       <= ptr_d;
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_shift_q  <= s1_shift_d;
      s1_ch_q     <= s1_ch_d;
      data_o_en_q <= data_o_en_d;
      data_o_q    <= data_o_d;
      ch_o_q      <= ch_o_d;
      ovf_o_q     <= ovf_o_d;
      ovf_cnt_q   <= ovf_cnt_d;
    end
  end

  assign data_o_en = data_o_en_q;
  assign data_o    = data_o_q;
  assign ch_o      = ch_o_q;
  assign ovf_o     = ovf_o_q;
  assign ovf_cnt   = ovf_cnt_q;
endmodule

// File: tb/tb_log_scale_arbiter.sv
// Bench for log_scale_arbiter: random and directed requests, arithmetic reference model,
// expected-result queue popped by an independent output monitor.
module tb_log_scale_arbiter;
  localparam int DW      = 25;
  localparam int N_CH    = 4;
  localparam int SHIFT_W = 5;
  localparam int CH_W    = 2;
  localparam int EW      = CH_W + DW + 1 + 16;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [N_CH-1:0]         req_valid = '0;
  logic [N_CH-1:0]         req_ready;
  logic [N_CH*DW-1:0]      req_data = '0;
  logic [N_CH*SHIFT_W-1:0] req_shift = '0;
  logic                    data_o_en;
  logic [DW-1:0]           data_o;
  logic [CH_W-1:0]         ch_o;
  logic                    ovf_o;
  logic [15:0]             ovf_cnt;

  log_scale_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_shift(req_shift), .data_o_en(data_o_en),
    .data_o(data_o), .ch_o(ch_o), .ovf_o(ovf_o), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [EW-1:0] exp_q[$];

  logic               rv [N_CH];
  logic [DW-1:0]      rd [N_CH];
  logic [SHIFT_W-1:0] rs [N_CH];
  int m_ptr = 0;
  int m_cnt = 0;
  int last_g = -1;
  int dut_g = -1;
  bit flush_next = 0;

  task automatic check(string name, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: treat the sample as an integer, multiply or floor-divide by 2^|s|.
  task automatic model(input logic [DW-1:0] d, input logic [SHIFT_W-1:0] sh,
                       output logic [DW-1:0] res, output bit ov);
    longint v, r, p, hi, lo;
    int s;
    v = longint'(d);
    if (d[DW-1]) v = v - (longint'(1) << DW);
    s = int'(sh);
    if (sh[SHIFT_W-1]) s = s - (1 << SHIFT_W);
    hi = (longint'(1) << (DW-1)) - 1;
    lo = -(longint'(1) << (DW-1));
    if (s >= 0) begin
      r  = v * (longint'(1) << s);
      ov = (r > hi) || (r < lo);
    end else begin
      p  = longint'(1) << (-s);
      r  = v / p;
      if (v < 0 && (v % p) != 0) r = r - 1;
      ov = 0;
    end
    res = r[DW-1:0];
`ifdef LOG_SCALE_SAT_EN
    if (ov) res = (v < 0) ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`endif
  endtask

  task automatic apply();
    for (int i = 0; i < N_CH; i++) begin
      req_valid[i] = rv[i];
      req_data[i*DW +: DW] = rd[i];
      req_shift[i*SHIFT_W +: SHIFT_W] = rs[i];
    end
  endtask

  // One clock: drive, check grant at the falling edge, record expectation, pass the rising edge.
  task automatic step();
    int g;
    logic [N_CH-1:0] exp_rdy;
    logic [DW-1:0] r;
    bit ov;
    apply();
    @(negedge clk);
    if (flush_next) begin
      exp_q.delete();
      flush_next = 0;
    end
    g = -1;
    if (!rst) begin
      for (int k = 0; k < N_CH; k++) begin
        if (g < 0 && rv[(m_ptr + k) % N_CH]) g = (m_ptr + k) % N_CH;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", longint'(req_ready), longint'(exp_rdy));
    dut_g = -1;
    for (int i = N_CH - 1; i >= 0; i--) if (req_ready[i]) dut_g = i;
    if (rst) begin
      m_ptr = 0;
      m_cnt = 0;
      flush_next = 1;
    end else if (g >= 0) begin
      model(rd[g], rs[g], r, ov);
      if (ov && m_cnt < 65535) m_cnt++;
      exp_q.push_back({CH_W'(g), r, ov, 16'(m_cnt)});
      m_ptr = (g + 1) % N_CH;
    end
    last_g = g;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (data_o_en) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got data_o_en=1 ch=%0d expected no result", ch_o);
      end else begin
        e = exp_q.pop_front();
        check("ch_o", longint'(ch_o), longint'(e[EW-1 -: CH_W]));
        check("data_o", longint'(data_o), longint'(e[DW+16 : 17]));
        check("ovf_o", longint'(ovf_o), longint'(e[16]));
        check("ovf_cnt", longint'(ovf_cnt), longint'(e[15:0]));
      end
    end
  end

  task automatic new_req(int i);
    rv[i] = 1'b1;
    case ($urandom_range(0, 3))
      0: rd[i] = DW'($urandom);
      1: rd[i] = DW'($urandom_range(0, 255));
      2: rd[i] = DW'(0) - DW'($urandom_range(1, 255));
      default: rd[i] = ($urandom_range(0, 1) != 0) ? {1'b0, {(DW-1){1'b1}}} : {1'b1, {(DW-1){1'b0}}};
    endcase
    rs[i] = SHIFT_W'($urandom_range(0, (1 << SHIFT_W) - 1));
  endtask

  task automatic idle_all();
    for (int i = 0; i < N_CH; i++) begin
      rv[i] = 1'b0; rd[i] = '0; rs[i] = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Lone request, then check the output two cycles after the transfer.
  task automatic single(int ch, logic [DW-1:0] d, logic [SHIFT_W-1:0] sh,
                        logic [DW-1:0] exp_d, logic exp_ov, logic [15:0] exp_cnt);
    rv[ch] = 1'b1; rd[ch] = d; rs[ch] = sh;
    step();
    rv[ch] = 1'b0;
    step();
    check("dir_en", longint'(data_o_en), 1);
    check("dir_data", longint'(data_o), longint'(exp_d));
    check("dir_ch", longint'(ch_o), longint'(ch));
    check("dir_ovf", longint'(ovf_o), longint'(exp_ov));
    check("dir_cnt", longint'(ovf_cnt), longint'(exp_cnt));
    step();
  endtask

  initial begin
    logic [DW-1:0] ovf_exp;
    idle_all();
    rst = 1'b1;
    step();
    step();
    check("rst_en", longint'(data_o_en), 0);
    check("rst_data", longint'(data_o), 0);
    check("rst_ch", longint'(ch_o), 0);
    check("rst_ovf", longint'(ovf_o), 0);
    check("rst_cnt", longint'(ovf_cnt), 0);
    rst = 1'b0;

    single(0, 25'h0000100, 5'd4,  25'h0001000, 1'b0, 16'd0);
    single(1, 25'h1FFFFF8, 5'h1E, 25'h1FFFFFE, 1'b0, 16'd0);
    single(2, 25'h1FFFFFF, 5'h1D, 25'h1FFFFFF, 1'b0, 16'd0);
    single(3, 25'h0000005, 5'h10, 25'h0000000, 1'b0, 16'd0);
`ifdef LOG_SCALE_SAT_EN
    ovf_exp = 25'h0FFFFFF;
`else
    ovf_exp = 25'h0000000;
`endif
    single(0, 25'h0800000, 5'd2, ovf_exp, 1'b1, 16'd1);

    // Rotation with every channel requesting, then a lone requester.
    do_reset();
    for (int i = 0; i < N_CH; i++) new_req(i);
    for (int k = 0; k < 8; k++) begin
      step();
      check("rr_order", dut_g, k % N_CH);
      new_req(last_g);
    end
    idle_all();
    rv[2] = 1'b1; rd[2] = 25'h0000123; rs[2] = 5'd1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("lone_grant", dut_g, 2);
    end
    idle_all();

    for (int c = 0; c < 3000; c++) begin
      step();
      for (int i = 0; i < N_CH; i++) begin
        if (last_g == i) begin
          if ($urandom_range(0, 1) != 0) new_req(i); else rv[i] = 1'b0;
        end else if (!rv[i] && $urandom_range(0, 9) < 4) begin
          new_req(i);
        end
      end
    end

    // Reset while results are in the pipeline.
    for (int i = 0; i < N_CH; i++) new_req(i);
    for (int k = 0; k < 4; k++) begin
      step();
      new_req(last_g);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("post_rst_en", longint'(data_o_en), 0);
    check("post_rst_cnt", longint'(ovf_cnt), 0);
    idle_all();
    rv[1] = 1'b1; rd[1] = 25'h0000040; rs[1] = 5'h1F;
    rv[3] = 1'b1; rd[3] = 25'h0000007; rs[3] = 5'd3;
    step();
    check("post_rst_grant", dut_g, 1);
    idle_all();
    for (int k = 0; k < 3; k++) step();
    check("queue_drained", exp_q.size(), 0);

    // Saturating overflow counter.
    do_reset();
    for (int i = 0; i < N_CH; i++) begin
      rv[i] = 1'b1; rd[i] = 25'h0800000; rs[i] = 5'd2;
    end
    for (int k = 0; k < 65540; k++) step();
    idle_all();
    for (int k = 0; k < 3; k++) step();
    check("ovf_cnt_sat", longint'(ovf_cnt), 65535);
    check("queue_empty_end", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/log_scale_arbiter.md
# log_scale_arbiter

Round-robin scheduler that shares one signed power-of-two scaling datapath among `N_CH` filter channels. Each channel presents a fixed-point sample and a signed shift amount over a valid/ready handshake. The block grants one channel per cycle and scales the sample by 2^shift. It returns the result tagged with the channel index. It sits between the per-channel filter taps and the accumulator stage, replacing one dedicated scaler per channel.

## Interface
- `width_H`, 5, integer bits of the two's-complement sample.
- `width_W`, 20, fractional bits; sample width `DW = width_H+width_W`.
- `N_CH`, 4, number of requesting channels (2..16).
- `SHIFT_W`, 5, width of the signed shift amount (range -2^(SHIFT_W-1) .. 2^(SHIFT_W-1)-1).
- `CH_W`, `$clog2(N_CH)`, channel index width (derived).
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  N_CH  per-channel request.
- `req_ready`  out  N_CH  per-channel grant, one-hot or zero, combinational from `req_valid` and the RR pointer.
- `req_data`  in  N_CH*DW  samples; channel i at bits [i*DW +: DW].
- `req_shift`  in  N_CH*SHIFT_W  signed shift amounts; channel i at [i*SHIFT_W +: SHIFT_W].
- `data_o_en`  out  1  result valid, one-cycle pulse per result.
- `data_o`  out  DW  scaled result.
- `ch_o`  out  CH_W  channel index of `data_o`.
- `ovf_o`  out  1  overflow flag for the current result (qualified by `data_o_en`).
- `ovf_cnt`  out  16  saturating count of overflowed results since reset.

## Operation
- Transfer on channel i: `req_valid[i] & req_ready[i]` in the same cycle. A requester holds its data and shift stable until the transfer.
- Arbitration: search from RR pointer `ptr` upward, modulo N_CH. The first valid channel is granted. After a transfer, `ptr <= granted+1` (wraps N_CH-1 -> 0). With no transfer, `ptr` holds. At most one grant per cycle. `req_ready` is all-zero while `rst` is high.
- Stage 1 (S1) registers: the granted sample, shift, index, and a valid bit.
- Stage 2 (S2) computes from the S1 registers:
  - shift s >= 0: `data << s`.
  - s < 0: arithmetic right shift by -s, which floors toward negative infinity.
- Right shift by >= DW yields 0 for non-negative inputs and all-ones (-1) for negative inputs.
- Overflow applies to left shifts only. It is set when any bit shifted out above bit DW-1, or the final sign bit, differs from the input sign. Left shift of a nonzero value by >= DW always overflows. Right shifts never overflow.
- Without saturation, the result is the low DW bits of the wide shift.
- `ovf_cnt` increments on each `data_o_en & ovf_o` and sticks at 0xFFFF.

## Timing
- Reset values: `data_o_en=0`, `data_o=0`, `ch_o=0`, `ovf_o=0`, `ovf_cnt=0`, `ptr=0`, S1 valid 0.
- Latency: transfer in cycle T gives `data_o_en=1` in cycle T+2. Throughput is one result per cycle. There is no output backpressure.
- `data_o`, `ch_o` and `ovf_o` hold their last values when `data_o_en=0`.
- Reset mid-operation: in-flight S1/S2 items are discarded. `data_o_en=0` in the cycle after `rst` is sampled high. The first grant after reset goes to the lowest valid channel.
- A single requester held valid is granted every cycle.
- With all channels valid, grants rotate 0,1,...,N_CH-1,0.

## Configuration
- `LOG_SCALE_SAT_EN` defined: on overflow, `data_o` clamps to the most positive value (0, then DW-1 ones) for non-negative input, or the most negative value (1, then DW-1 zeros) for negative input. `ovf_o` is still asserted.
- Not defined: the result wraps (low DW bits). `ovf_o` and `ovf_cnt` behave identically in both builds.

## Test plan
- Reset with defaults, ch0 data 0x0000100, shift +4: `data_o=0x0001000`, `ch_o=0`, `ovf_o=0`, two cycles after the transfer.
- ch1 data 0x1FFFFF8 (-8), shift -2: `data_o=0x1FFFFFE`. ch2 data 0x1FFFFFF, shift -3: `data_o=0x1FFFFFF`. ch3 data 0x0000005, shift -16: `data_o=0`.
- ch0 data 0x0800000, shift +2: `ovf_o=1`, `ovf_cnt=1`. Without the macro `data_o=0x0000000`; with `LOG_SCALE_SAT_EN`, `data_o=0x0FFFFFF`.
- All four channels valid for 8 cycles: grant order 0,1,2,3,0,1,2,3, and `ch_o` follows the same order 2 cycles later. Then only ch2 valid: granted every cycle.
- Assert `rst` for 1 cycle while two results are in flight: no `data_o_en` pulse for those items. `ovf_cnt=0`. The next grant goes to the lowest valid channel.
- Drive 65540 overflowing requests: `ovf_cnt` stops at 0xFFFF.
